i2c_controller: RTL and testbench

I2C_CONTROLLER -- requirements
Module: i2c_controller

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_clk_gen.sv | 45 ++++
 rtl/i2c_controller.sv | 161 ++++++++++++++++
 tb/tb_i2c_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C controller types: FSM states, slot/quarter constants, R/W bit encodings.
// No logic; imported by i2c_clk_gen and i2c_controller.
// No flow control.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    DATA_W,
    DATA_R,
    ACK_D,
    STOP
  } i2c_state_t;

  localparam int QUARTERS_PER_SLOT = 4;
  localparam int BITS_PER_BYTE     = 8;

  localparam logic [1:0] Q_LAST         = 2'(QUARTERS_PER_SLOT - 1);
  // Quarter indices are the quarter being left when the strobe fires.
  localparam logic [1:0] Q_SAMPLE_PRE   = 2'd1;
  localparam logic [1:0] Q_STOP_REL_PRE = 2'd2;
  localparam logic [2:0] BIT_LAST       = 3'(BITS_PER_BYTE - 1);

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase strobe generator: tick marks each quarter boundary, slot_end the bit-slot boundary.
// Latency: first tick CLK_DIV cycles after run rises; counters held at zero while run is low.
// No backpressure; free-running while run is high.
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [1:0] quarter,
  output logic       tick,
  output logic       slot_end,
  output logic       scl_nxt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [1:0]    quarter_nxt;

  assign quarter_nxt = quarter + 2'd1;
  assign tick        = run && (div_cnt == DIV_LAST);
  assign slot_end    = tick && (quarter == Q_LAST);
  // SCL level for the quarter that starts on the coming tick.
  assign scl_nxt     = quarter_nxt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      quarter <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      quarter <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      quarter <= quarter_nxt;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-byte I2C master (START, addr+R/W, ACK, data, ACK, STOP); read path built only with I2C_READ_EN.
// Latency: a full acked transaction takes 20 slots = 80*CLK_DIV clk cycles after the enable edge.
// Backpressure: enable edges while busy are dropped, inputs are captured only at start.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic [7:0] wr_byte,
  input  logic [6:0] periph_addr,
  output logic       sdc,
  inout  wire        sda,
  output logic       busy,
  output logic       nack,
  output logic [7:0] rx_data
);

  i2c_state_t               state;
  logic                     enable_q;
  logic                     sda_oe;
  logic                     is_read;
  logic                     ack_bit;
  logic [2:0]               bit_cnt;
  logic [BITS_PER_BYTE-1:0] tx_sr;
  logic [BITS_PER_BYTE-1:0] byte_q;
  logic [1:0]               quarter;
  logic                     tick;
  logic                     slot_end;
  logic                     scl_nxt;
  logic                     start_req;
  logic                     rw_bit;

  assign sda       = sda_oe ? 1'b0 : 1'bz;
  assign start_req = enable && !enable_q && (state == IDLE);

`ifdef I2C_READ_EN
  logic [BITS_PER_BYTE-1:0] rx_sr;
  assign rw_bit = mode ? RW_WRITE : RW_READ;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rw_bit      = RW_WRITE;
  assign rx_data     = '0;
`endif

  i2c_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (busy),
    .quarter (quarter),
    .tick    (tick),
    .slot_end(slot_end),
    .scl_nxt (scl_nxt)
  );

  // Outputs are registered for the quarter about to begin, so they line up with the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      sdc      <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      nack     <= 1'b0;
      is_read  <= 1'b0;
      ack_bit  <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      byte_q   <= '0;
`ifdef I2C_READ_EN
      rx_sr    <= '0;
      rx_data  <= '0;
`endif
    end else begin
      enable_q <= enable;
      if (start_req) begin
        state   <= START;
        busy    <= 1'b1;
        nack    <= 1'b0;
        byte_q  <= wr_byte;
        tx_sr   <= {periph_addr, rw_bit};
        is_read <= (rw_bit == RW_READ);
        bit_cnt <= '0;
        sdc     <= 1'b1;
        sda_oe  <= 1'b1;
      end else if (tick) begin
        sdc <= (state == START && !slot_end) ? ~scl_nxt : scl_nxt;
        if (quarter == Q_SAMPLE_PRE) begin
          if (state == ACK_A || state == ACK_D) ack_bit <= sda;
`ifdef I2C_READ_EN
          if (state == DATA_R) rx_sr <= {rx_sr[BITS_PER_BYTE-2:0], sda};
`endif
        end
        if (state == STOP && quarter == Q_STOP_REL_PRE) sda_oe <= 1'b0;
        if (slot_end) begin
          case (state)
            START: begin
              state  <= ADDR;
              sda_oe <= ~tx_sr[7];
            end
            ADDR, DATA_W: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) begin
                state  <= (state == ADDR) ? ACK_A : ACK_D;
                sda_oe <= 1'b0;
              end else begin
                tx_sr  <= {tx_sr[BITS_PER_BYTE-2:0], 1'b0};
                sda_oe <= ~tx_sr[6];
              end
            end
`ifdef I2C_READ_EN
            DATA_R: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) state <= ACK_D;
            end
`endif
            ACK_A: begin
              if (ack_bit) begin
                nack   <= 1'b1;
                state  <= STOP;
                sda_oe <= 1'b1;
              end
`ifdef I2C_READ_EN
              else if (is_read) begin
                state  <= DATA_R;
                sda_oe <= 1'b0;
              end
`endif
              else begin
                state  <= DATA_W;
                tx_sr  <= byte_q;
                sda_oe <= ~byte_q[7];
              end
            end
            ACK_D: begin
              state  <= STOP;
              sda_oe <= 1'b1;
              if (!is_read && ack_bit) nack <= 1'b1;
`ifdef I2C_READ_EN
              if (is_read) rx_data <= rx_sr;
`endif
            end
            default: begin
              state  <= IDLE;
              busy   <= 1'b0;
              sdc    <= 1'b1;
              sda_oe <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller: bus monitor plus a simple peripheral model on SDA.
module tb_i2c_controller;

  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset, enable, mode;
  logic [7:0] wr_byte;
  logic [6:0] periph_addr;
  logic       sdc, busy, nack;
  logic [7:0] rx_data;
  wire        sda;

  logic       periph_low;
  logic       ack_addr, ack_data, periph_read;
  logic [7:0] periph_dat;

  int n_checks = 0;
  int n_fail   = 0;

  pullup (sda);
  assign sda = periph_low ? 1'b0 : 1'bz;

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .wr_byte    (wr_byte),
    .periph_addr(periph_addr),
    .sdc        (sdc),
    .sda        (sda),
    .busy       (busy),
    .nack       (nack),
    .rx_data    (rx_data)
  );

  always #5 clk = ~clk;

  // Bus monitor: SDA logged on each SCL rise, START/STOP conditions and transactions counted.
  logic        sdc_d, sda_d, busy_d;
  int          fall_n = 0, nbits = 0, busy_cycles = 0;
  int          start_cnt = 0, stop_cnt = 0, txn_cnt = 0;
  logic [31:0] bit_sr = '0;

  always @(posedge clk) begin
    sdc_d  <= sdc;
    sda_d  <= sda;
    busy_d <= busy;
    if (busy && !busy_d) begin
      busy_cycles <= 1;
      txn_cnt     <= txn_cnt + 1;
      nbits       <= 0;
    end else if (busy) begin
      busy_cycles <= busy_cycles + 1;
    end
    if (!busy) fall_n <= 0;
    else if (sdc_d && !sdc) fall_n <= fall_n + 1;
    if (busy && sdc && !sdc_d) begin
      bit_sr <= {bit_sr[30:0], sda};
      nbits  <= nbits + 1;
    end
    if (sdc && sdc_d && sda_d && !sda) start_cnt <= start_cnt + 1;
    if (sdc && sdc_d && !sda_d && sda) stop_cnt <= stop_cnt + 1;
  end

  // Peripheral: slot n begins at SCL fall number n+1 (fall 1 is inside START).
  always_comb begin
    periph_low = 1'b0;
    if (busy) begin
      if (fall_n == 9) periph_low = ack_addr;
      else if (periph_read && fall_n >= 10 && fall_n <= 17) periph_low = !periph_dat[3'(17 - fall_n)];
      else if (!periph_read && fall_n == 18) periph_low = ack_data;
    end
  end

  task automatic pulse_txn(input logic [6:0] a, input logic [7:0] d, input logic m, input int len);
    @(negedge clk);
    periph_addr = a;
    wr_byte     = d;
    mode        = m;
    enable      = 1'b1;
    repeat (len) @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; mode = 1'b1; wr_byte = '0; periph_addr = '0;
    ack_addr = 1'b1; ack_data = 1'b1; periph_read = 1'b0; periph_dat = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (sdc !== 1'b1) begin n_fail++; $display("FAIL reset_sdc: got %b want 1", sdc); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b want 0", nack); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
  endtask

  task automatic test_write_ack;
    logic ok;
    int t0 = txn_cnt, s0 = start_cnt, p0 = stop_cnt;
    logic [18:0] exp_bits = {8'h0A, 1'b0, 8'h07, 1'b0, 1'b0};
    pulse_txn(7'd5, 8'h07, 1'b1, 4);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_timeout: busy still %b", busy); end
    n_checks++; if (busy_cycles !== 20 * SLOT) begin n_fail++; $display("FAIL wr_busy_len: got %0d want %0d", busy_cycles, 20 * SLOT); end
    n_checks++; if (nbits !== 19) begin n_fail++; $display("FAIL wr_nbits: got %0d want 19", nbits); end
    n_checks++; if (bit_sr[18:0] !== exp_bits) begin n_fail++; $display("FAIL wr_bits: got %b want %b", bit_sr[18:0], exp_bits); end
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL wr_nack: got %b want 0", nack); end
    n_checks++; if (txn_cnt - t0 !== 1) begin n_fail++; $display("FAIL wr_txn: got %0d want 1", txn_cnt - t0); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL wr_start: got %0d want 1", start_cnt - s0); end
    n_checks++; if (stop_cnt - p0 !== 1) begin n_fail++; $display("FAIL wr_stop: got %0d want 1", stop_cnt - p0); end
    n_checks++; if ({sdc, sda} !== 2'b11) begin n_fail++; $display("FAIL wr_idle_bus: got %b want 11", {sdc, sda}); end
  endtask

  task automatic test_write_nack;
    logic ok;
    int p0 = stop_cnt;
    logic [9:0] exp_bits = {8'h0A, 1'b1, 1'b0};
    ack_addr = 1'b0;
    pulse_txn(7'd5, 8'h07, 1'b1, 4);
    wait_idle(ok);
    ack_addr = 1'b1;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL nack_timeout: busy still %b", busy); end
    n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_flag: got %b want 1", nack); end
    n_checks++; if (busy_cycles !== 11 * SLOT) begin n_fail++; $display("FAIL nack_busy_len: got %0d want %0d", busy_cycles, 11 * SLOT); end
    n_checks++; if (nbits !== 10) begin n_fail++; $display("FAIL nack_nbits: got %0d want 10", nbits); end
    n_checks++; if (bit_sr[9:0] !== exp_bits) begin n_fail++; $display("FAIL nack_bits: got %b want %b", bit_sr[9:0], exp_bits); end
    n_checks++; if (stop_cnt - p0 !== 1) begin n_fail++; $display("FAIL nack_stop: got %0d want 1", stop_cnt - p0); end
  endtask

  task automatic test_read;
    logic ok;
    int p0 = stop_cnt;
`ifdef I2C_READ_EN
    logic [18:0] exp_bits = {8'h55, 1'b0, 8'hA5, 1'b1, 1'b0};
    logic [7:0]  exp_rx   = 8'hA5;
    periph_read = 1'b1;
    periph_dat  = 8'hA5;
`else
    logic [18:0] exp_bits = {8'h54, 1'b0, 8'h3C, 1'b0, 1'b0};
    logic [7:0]  exp_rx   = 8'h00;
`endif
    pulse_txn(7'h2A, 8'h3C, 1'b0, 4);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL rd_nack_clear: got %b want 0", nack); end
    wait_idle(ok);
    periph_read = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_timeout: busy still %b", busy); end
    n_checks++; if (bit_sr[18:0] !== exp_bits) begin n_fail++; $display("FAIL rd_bits: got %b want %b", bit_sr[18:0], exp_bits); end
    n_checks++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rd_rx_data: got %h want %h", rx_data, exp_rx); end
    n_checks++; if (busy_cycles !== 20 * SLOT) begin n_fail++; $display("FAIL rd_busy_len: got %0d want %0d", busy_cycles, 20 * SLOT); end
    n_checks++; if (stop_cnt - p0 !== 1) begin n_fail++; $display("FAIL rd_stop: got %0d want 1", stop_cnt - p0); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int p0, t0;
    logic [18:0] exp_bits = {8'h22, 1'b0, 8'hC3, 1'b0, 1'b0};
    pulse_txn(7'd5, 8'h07, 1'b1, 4);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fall_n == 13) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_reach_data: fall count %0d want 13", fall_n); end
    p0 = stop_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (sdc !== 1'b1) begin n_fail++; $display("FAIL mid_sdc: got %b want 1", sdc); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL mid_sda: got %b want 1", sda); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (stop_cnt - p0 !== 0) begin n_fail++; $display("FAIL mid_no_stop: got %0d want 0", stop_cnt - p0); end
    t0 = txn_cnt;
    pulse_txn(7'h11, 8'hC3, 1'b1, 4);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_timeout: busy still %b", busy); end
    n_checks++; if (bit_sr[18:0] !== exp_bits) begin n_fail++; $display("FAIL mid_bits: got %b want %b", bit_sr[18:0], exp_bits); end
    n_checks++; if (busy_cycles !== 20 * SLOT) begin n_fail++; $display("FAIL mid_busy_len: got %0d want %0d", busy_cycles, 20 * SLOT); end
    n_checks++; if (txn_cnt - t0 !== 1) begin n_fail++; $display("FAIL mid_txn: got %0d want 1", txn_cnt - t0); end
  endtask

  task automatic test_enable_held;
    int t0 = txn_cnt;
    @(negedge clk);
    periph_addr = 7'd5; wr_byte = 8'h07; mode = 1'b1; enable = 1'b1;
    repeat (1000) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (txn_cnt - t0 !== 1) begin n_fail++; $display("FAIL held_txn: got %0d want 1", txn_cnt - t0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy_drop;
    logic ok;
    int t0 = txn_cnt;
    logic [18:0] exp_bits = {8'h42, 1'b0, 8'h5A, 1'b0, 1'b0};
    pulse_txn(7'h21, 8'h5A, 1'b1, 2);
    repeat (50) @(negedge clk);
    pulse_txn(7'h7F, 8'hFF, 1'b0, 3);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL drop_timeout: busy still %b", busy); end
    n_checks++; if (bit_sr[18:0] !== exp_bits) begin n_fail++; $display("FAIL drop_bits: got %b want %b", bit_sr[18:0], exp_bits); end
    repeat (50) @(negedge clk);
    n_checks++; if (txn_cnt - t0 !== 1) begin n_fail++; $display("FAIL drop_txn: got %0d want 1", txn_cnt - t0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ack();
    test_write_nack();
    test_read();
    test_reset_mid();
    test_enable_held();
    test_busy_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
